// File: rtl/switch_mmio_reader.sv
`default_nettype none
// switch_mmio_reader -- debounced switch inputs with W1C edge events, change counter and IRQ,
// served as a 16-byte word window on the MEM-stage load/store bus.  Rev 1.0
module switch_mmio_reader #(
   parameter int unsigned NUM_SW          = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter logic [31:0] BASE_ADDR       = 32'hFFFF_0010
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_SW-1:0] switches,
   input  logic [31:0]       mem_addr,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [31:0]       mem_wdata,
   output logic              rd_hit,
   output logic [31:0]       rd_data,
   output logic              irq
);
   localparam int unsigned   c_CW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned   c_NE   = 2 * NUM_SW;
   localparam logic [c_CW-1:0] c_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

   logic [NUM_SW-1:0] r_sync1;
   logic [NUM_SW-1:0] r_sync2;
   logic [NUM_SW-1:0] w_stable;
   logic [NUM_SW-1:0] w_rise;
   logic [NUM_SW-1:0] w_fall;
   logic [c_NE-1:0]   w_evt_set;
   logic [c_NE-1:0]   r_events;
   logic [c_NE-1:0]   r_irq_en;
   logic [15:0]       r_count;
   logic              w_hit;
   logic              w_wr;
   logic [1:0]        w_sel;
   logic [31:0]       w_rdata;
   logic              w_unused;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= switches;
         r_sync2 <= r_sync1;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_bit
         logic [c_CW-1:0] r_cnt;
         logic            r_stable;
         logic            w_accept;

         // Any return of sync to the stable level restarts the qualification window.
         assign w_accept = (r_sync2[gi] != r_stable) && (r_cnt == c_LAST);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_cnt    <= '0;
               r_stable <= 1'b0;
            end else if (r_sync2[gi] == r_stable) begin
               r_cnt <= '0;
            end else if (w_accept) begin
               r_cnt    <= '0;
               r_stable <= r_sync2[gi];
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end

         assign w_stable[gi] = r_stable;
         assign w_rise[gi]   = w_accept & r_sync2[gi];
         assign w_fall[gi]   = w_accept & ~r_sync2[gi];
      end
   endgenerate

   assign w_evt_set = {w_fall, w_rise};
   assign w_hit     = (mem_addr[31:4] == BASE_ADDR[31:4]);
   assign w_wr      = mem_write & w_hit;
   assign w_sel     = mem_addr[3:2];

   // New events are OR'd after the W1C mask so a same-cycle set survives the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_events <= '0;
         r_irq_en <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr && (w_sel == 2'd1)) begin
            r_events <= (r_events & ~mem_wdata[c_NE-1:0]) | w_evt_set;
         end else begin
            r_events <= r_events | w_evt_set;
         end
         if (w_wr && (w_sel == 2'd2)) begin
            r_irq_en <= mem_wdata[c_NE-1:0];
         end
         if (w_wr && (w_sel == 2'd3)) begin
            r_count <= '0;
         end else if (|w_evt_set) begin
            r_count <= r_count + 16'd1;
         end
      end
   end

   always_comb begin
      w_rdata = '0;
      case (w_sel)
         2'd0:    w_rdata[NUM_SW-1:0] = w_stable;
         2'd1:    w_rdata[c_NE-1:0]   = r_events;
         2'd2:    w_rdata[c_NE-1:0]   = r_irq_en;
         default: w_rdata[15:0]       = r_count;
      endcase
   end

   assign rd_hit   = mem_read & w_hit;
   assign rd_data  = rd_hit ? w_rdata : 32'd0;
   assign irq      = |(r_events & r_irq_en);
   assign w_unused = ^{mem_addr[1:0], mem_wdata};

endmodule
`default_nettype wire

// File: tb/tb_switch_mmio_reader.sv
`default_nettype none
// tb_switch_mmio_reader -- directed scenarios plus random traffic checked every cycle
// against a timestamp-based behavioural model of the switch peripheral.  Rev 1.0
module tb_switch_mmio_reader;
   localparam int          NSW  = 4;
   localparam int          DB   = 8;
   localparam logic [31:0] BASE = 32'hFFFF_0010;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic [3:0]  switches  = 4'h0;
   logic [31:0] mem_addr  = 32'h0;
   logic        mem_read  = 1'b0;
   logic        mem_write = 1'b0;
   logic [31:0] mem_wdata = 32'h0;
   logic        rd_hit;
   logic [31:0] rd_data;
   logic        irq;

   switch_mmio_reader #(
      .NUM_SW          (NSW),
      .DEBOUNCE_CYCLES (DB),
      .BASE_ADDR       (BASE)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .switches  (switches),
      .mem_addr  (mem_addr),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_wdata (mem_wdata),
      .rd_hit    (rd_hit),
      .rd_data   (rd_data),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a pin level is accepted once its synchronized copy has held a value
   // different from the accepted level for DB edges (tracked by change timestamps).
   logic [3:0]  m_s1, m_s2, m_stable;
   int          m_chg [4];
   int          m_cyc;
   logic [7:0]  m_events, m_irqen;
   logic [15:0] m_count;
   bit          ovr_en  = 1'b0;
   logic [15:0] ovr_val = 16'h0;
   bit          cmp_en  = 1'b1;

   always @(posedge clk or negedge rst_n) begin : model
      logic [3:0] acc;
      logic [7:0] clr;
      logic       hit;
      if (!rst_n) begin
         m_s1 <= '0; m_s2 <= '0; m_stable <= '0; m_cyc <= 0;
         for (int i = 0; i < 4; i++) m_chg[i] <= 0;
         m_events <= '0; m_irqen <= '0; m_count <= '0;
      end else begin
         acc = '0;
         for (int i = 0; i < 4; i++) begin
            if (m_s2[i] != m_stable[i] && (m_cyc + 1 - m_chg[i]) >= DB) acc[i] = 1'b1;
            if (m_s1[i] != m_s2[i]) m_chg[i] <= m_cyc + 1;
         end
         m_s1     <= switches;
         m_s2     <= m_s1;
         m_cyc    <= m_cyc + 1;
         m_stable <= m_stable ^ acc;
         hit = mem_write && (mem_addr[31:4] == BASE[31:4]);
         clr = (hit && mem_addr[3:2] == 2'd1) ? mem_wdata[7:0] : 8'h0;
         m_events <= (m_events & ~clr) | {acc & m_stable, acc & ~m_stable};
         if (hit && mem_addr[3:2] == 2'd2) m_irqen <= mem_wdata[7:0];
         if (hit && mem_addr[3:2] == 2'd3) m_count <= 16'h0;
         else if (|acc)                    m_count <= (ovr_en ? ovr_val : m_count) + 16'd1;
         else if (ovr_en)                  m_count <= ovr_val;
      end
   end

   always @(negedge clk) begin : compare
      logic        h;
      logic [31:0] exp;
      if (cmp_en) begin
         h   = mem_read && (mem_addr[31:4] == BASE[31:4]);
         exp = 32'h0;
         if (h) begin
            case (mem_addr[3:2])
               2'd0:    exp = {28'h0, m_stable};
               2'd1:    exp = {24'h0, m_events};
               2'd2:    exp = {24'h0, m_irqen};
               default: exp = {16'h0, m_count};
            endcase
         end
         chk("cyc_rd_hit", {31'h0, rd_hit}, {31'h0, h});
         chk("cyc_rd_data", rd_data, exp);
         chk("cyc_irq", {31'h0, irq}, {31'h0, |(m_events & m_irqen)});
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [3:0] off, input logic [31:0] d);
      mem_addr  = BASE + {28'h0, off};
      mem_wdata = d;
      mem_write = 1'b1;
      step();
      mem_write = 1'b0;
   endtask

   task automatic rd(input string nm, input logic [3:0] off, input logic [31:0] exp);
      mem_addr = BASE + {28'h0, off};
      mem_read = 1'b1;
      #1;
      chk(nm, rd_data, exp);
      mem_read = 1'b0;
   endtask

   initial begin
      // Reset held while pins toggle
      for (int i = 0; i < 6; i++) begin
         switches = 4'(i * 5);
         step();
      end
      rd("rst_status", 4'h0, 32'h0);
      rd("rst_events", 4'h4, 32'h0);
      rd("rst_irqen",  4'h8, 32'h0);
      rd("rst_count",  4'hC, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      switches = 4'h0;
      rst_n    = 1'b1;
      step(50);
      rd("idle_status", 4'h0, 32'h0);
      rd("idle_count",  4'hC, 32'h0);

      // Clean press: accepted on the 10th edge
      switches = 4'b0001;
      step(9);
      rd("press_edge9", 4'h0, 32'h0);
      step(1);
      rd("press_edge10", 4'h0, 32'h1);
      rd("press_events", 4'h4, 32'h01);
      rd("press_count",  4'hC, 32'h1);

      // Bounce on switch[1]
      wr(4'h4, 32'hFF);
      wr(4'hC, 32'h0);
      for (int k = 0; k < 5; k++) begin
         switches[1] = 1'b1; step(7);
         switches[1] = 1'b0; step(1);
      end
      switches[1] = 1'b1;
      step(9);
      rd("bounce_edge9", 4'h0, 32'h1);
      step(1);
      rd("bounce_edge10", 4'h0, 32'h3);
      rd("bounce_events", 4'h4, 32'h02);
      rd("bounce_count",  4'hC, 32'h1);

      // W1C and IRQ
      wr(4'h4, 32'hFF);
      wr(4'h8, 32'h10);
      switches[0] = 1'b0;
      step(10);
      rd("irq_events", 4'h4, 32'h10);
      chk("irq_set", {31'h0, irq}, 32'h1);
      wr(4'h4, 32'h10);
      chk("irq_clr", {31'h0, irq}, 32'h0);
      switches[1] = 1'b0;
      step(9);
      wr(4'h4, 32'h20);
      rd("w1c_vs_set", 4'h4, 32'h20);

      // Multi-bit change, then COUNT clear on an increment edge
      wr(4'h4, 32'hFF);
      wr(4'hC, 32'h0);
      switches = 4'hF;
      step(10);
      rd("multi_count",  4'hC, 32'h1);
      rd("multi_events", 4'h4, 32'h0F);
      switches = 4'h0;
      step(9);
      wr(4'hC, 32'h0);
      rd("cnt_clr_wins", 4'hC, 32'h0);
      rd("multi_events2", 4'h4, 32'hFF);

      // Reset mid-debounce discards the partial count
      switches = 4'b0100;
      step(5);
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      step(9);
      rd("rstmid_status9", 4'h0, 32'h0);
      rd("rstmid_events9", 4'h4, 32'h0);
      step(1);
      rd("rstmid_status10", 4'h0, 32'h4);

      // Decode
      mem_addr = BASE + 32'h14;
      mem_read = 1'b1;
      #1;
      chk("miss_rd_hit", {31'h0, rd_hit}, 32'h0);
      chk("miss_rd_data", rd_data, 32'h0);
      mem_read  = 1'b0;
      mem_addr  = BASE + 32'h18;
      mem_wdata = 32'hFF;
      mem_write = 1'b1;
      step();
      mem_write = 1'b0;
      rd("miss_store", 4'h8, 32'h0);
      wr(4'h0, 32'hF);
      rd("status_ro", 4'h0, 32'h4);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         int b;
         if ($urandom_range(0, 15) == 0) begin
            b = $urandom_range(0, 3);
            switches[b] = ~switches[b];
         end
         mem_addr  = BASE + (($urandom_range(0, 7) == 0) ? 32'h10 : 32'h0) + 32'($urandom_range(0, 15));
         mem_read  = ($urandom_range(0, 1) == 1);
         mem_write = ($urandom_range(0, 7) == 0);
         mem_wdata = $urandom;
         step();
      end
      mem_read  = 1'b0;
      mem_write = 1'b0;

      // COUNT wrap 0xFFFF -> 0
      step(20);
      cmp_en  = 1'b0;
      force dut.r_count = 16'hFFFF;
      ovr_val = 16'hFFFF;
      ovr_en  = 1'b1;
      step(1);
      ovr_en  = 1'b0;
      release dut.r_count;
      cmp_en  = 1'b1;
      rd("wrap_pre", 4'hC, 32'hFFFF);
      switches[0] = ~switches[0];
      step(10);
      rd("wrap_post", 4'hC, 32'h0);
      step(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/switch_mmio_reader.md
# switch_mmio_reader

Memory-mapped input peripheral for the riscv5stage core: the read-side counterpart to the LED MMIO write path. It synchronizes and debounces the board `switches`, records rising and falling edges as sticky W1C event bits, counts accepted changes, and serves word loads from the core's MEM stage. It sits beside the data memory on the MEM-stage load/store bus and raises a level interrupt on masked events.

## Interface
Parameters:
- `NUM_SW`, 4: number of switch inputs, 1..16.
- `DEBOUNCE_CYCLES`, 1000: consecutive stable cycles required to accept a change, ≥1 (10 µs at 100 MHz).
- `BASE_ADDR`, 32'hFFFF_0010: base of the 16-byte register window; bits [3:0] must be 0.

Ports:
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `switches` in NUM_SW: raw asynchronous switch pins.
- `mem_addr` in 32: MEM-stage byte address (ALU result).
- `mem_read` in 1: MEM-stage load strobe.
- `mem_write` in 1: MEM-stage store strobe.
- `mem_wdata` in 32: store data.
- `rd_hit` out 1: load addresses this window this cycle.
- `rd_data` out 32: load data; 0 when `rd_hit`=0.
- `irq` out 1: `|(EVENTS & IRQ_EN)`.

## Operation
- Decode: hit when `mem_addr[31:4]==BASE_ADDR[31:4]`. Register selected by `mem_addr[3:2]`; `mem_addr[1:0]` ignored; word access only.
- Registers:
  - 0x0 STATUS (RO): [NUM_SW-1:0] debounced level. Writes ignored.
  - 0x4 EVENTS (W1C): rise in [NUM_SW-1:0], fall in [2*NUM_SW-1:NUM_SW]. Write 1 clears, 0 has no effect.
  - 0x8 IRQ_EN (RW): [2*NUM_SW-1:0] mask. Bits above read 0.
  - 0xC COUNT (RW-clear): [15:0] accepted-change count. Any write clears it. Wraps 0xFFFF→0. Bits [31:16] read 0.
- Per bit: 2-flop synchronizer → `sync`. Per-bit counter, width `$clog2(DEBOUNCE_CYCLES+1)`:
  - `sync==stable`: counter ← 0.
  - `sync!=stable` and counter<DEBOUNCE_CYCLES-1: counter increments.
  - `sync!=stable` and counter==DEBOUNCE_CYCLES-1: `stable`←`sync`, counter←0, and the matching rise/fall event bit is set.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is rejected. The counter restarts on every bounce.
- COUNT increments by 1 in each cycle in which at least one `stable` bit changes, regardless of how many bits change.
- Simultaneous events:
  - Event set and W1C clear of the same bit in the same cycle: set wins (bit stays 1).
  - COUNT write and increment in the same cycle: clear wins, result 0.
  - Load and update of a register in the same cycle: the load returns the pre-edge value.
- Stores with `mem_write` and no hit are ignored. `mem_read` and `mem_write` both high with a hit: the write takes effect and the read data is still returned.

## Timing
- Reset (async assert, sync release on `clk`): synchronizers, `stable`, counters, EVENTS, IRQ_EN, and COUNT are 0. `rd_hit`=0, `rd_data`=0, `irq`=0.
- Switches already high at reset release produce rise events after the normal debounce latency. This is intended.
- Pin change → STATUS: `stable` updates on the (DEBOUNCE_CYCLES+2)th rising edge after the pin change, with the pin held throughout. The event bit and COUNT update on the same edge.
- `irq` is combinational from registers and asserts in the same cycle the event or enable bit becomes visible.
- Reads are combinational, zero-latency, matching the single-cycle MEM-stage data memory path. Writes take effect at the next rising edge.
- Reset asserted mid-debounce discards the partial count. No event is generated.

## Test plan
All scenarios use DEBOUNCE_CYCLES=8 and NUM_SW=4.
- Reset: hold `rst_n`=0, toggle switches → STATUS, EVENTS, COUNT, IRQ_EN, and `irq` all read 0. Release with switches=0 → all remain 0 for 50 cycles.
- Clean press: switches 0000→0001 held → STATUS reads 0x1 exactly 10 edges later. EVENTS=0x01, COUNT=1.
- Bounce: switch[1] toggled high for 7 cycles, low for 1 cycle, ×5, then held high → only one rise event, EVENTS[1]=1, COUNT=1. STATUS[1] rises 10 edges after the final rising transition.
- W1C and IRQ:
  - Write IRQ_EN=0x10, then release switch[0] → EVENTS=0x10 and `irq`=1.
  - Write EVENTS=0x10 → `irq`=0 next cycle.
  - W1C on the exact accept edge of a new fall → bit stays 1.
- Multi-bit change: switches 0000→1111 together → COUNT +1 only, EVENTS=0x0F. Write COUNT on an increment edge → COUNT reads 0.
- Decode: load at BASE_ADDR+0x14 → `rd_hit`=0, `rd_data`=0. Store to STATUS → no change. COUNT wraps 0xFFFF→0x0000 after 65536 accepted toggles (force or run).
